// File: rtl/lane_mem_coalescer_if.sv
// Bundle of core-request, memory-port and response signals seen by lane_mem_coalescer.
// The coalescer sits on the slave modport; the core/memory environment uses master.
interface lane_mem_coalescer_if #(
  parameter int LANES  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int LW = $clog2(LANES) + 1;

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [LANES-1:0]          req_mask;
  logic [LANES*ADDR_W-1:0]   req_addr;
  logic [LANES*DATA_W-1:0]   req_wdata;

  logic                      mem_cmd_valid;
  logic                      mem_cmd_ready;
  logic                      mem_cmd_write;
  logic [ADDR_W-1:0]         mem_cmd_addr;
  logic [LW-1:0]             mem_cmd_len;

  logic                      mem_wvalid;
  logic                      mem_wready;
  logic [DATA_W-1:0]         mem_wdata;

  logic                      mem_rvalid;
  logic [DATA_W-1:0]         mem_rdata;

  logic                      resp_valid;
  logic [LANES*DATA_W-1:0]   resp_rdata;

  modport slave (
    input  req_valid, req_write, req_mask, req_addr, req_wdata,
    output req_ready,
    output mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_len,
    input  mem_cmd_ready,
    output mem_wvalid, mem_wdata,
    input  mem_wready,
    input  mem_rvalid, mem_rdata,
    output resp_valid, resp_rdata
  );

  modport master (
    output req_valid, req_write, req_mask, req_addr, req_wdata,
    input  req_ready,
    input  mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_len,
    output mem_cmd_ready,
    input  mem_wvalid, mem_wdata,
    output mem_wready,
    output mem_rvalid, mem_rdata,
    input  resp_valid, resp_rdata
  );
endinterface

// File: rtl/lane_mem_coalescer.sv
// Warp-wide load/store coalescer: one burst for a contiguous access, otherwise per-lane
// single-word commands with duplicate read addresses fetched once and broadcast.
module lane_mem_coalescer #(
  parameter int LANES  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                 clk,
  input logic                 reset,
  lane_mem_coalescer_if.slave bus
);
  localparam int IW = $clog2(LANES);
  localparam int LW = IW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_CMD, S_WDATA, S_RDATA, S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [LANES-1:0]  mask_q,  mask_d;
  logic [LANES-1:0]  pend_q,  pend_d;
  logic [LW-1:0]     len_q,   len_d;
  logic [IW-1:0]     lane_q,  lane_d;
  logic [IW-1:0]     beat_q,  beat_d;
  logic [ADDR_W-1:0] addr_q  [LANES];
  logic [ADDR_W-1:0] addr_d  [LANES];
  logic [DATA_W-1:0] wdata_q [LANES];
  logic [DATA_W-1:0] wdata_d [LANES];
  logic [DATA_W-1:0] rdata_q [LANES];
  logic [DATA_W-1:0] rdata_d [LANES];

  // Request decode, consumed in CHECK (first/last lane, contiguity, lanes that must issue)
  logic [IW-1:0]     first, last, cur;
  logic              adj;
  logic [LANES-1:0]  issue;

  always_comb begin
    first = '0;
    last  = '0;
    for (int i = LANES-1; i >= 0; i--) if (mask_q[i]) first = IW'(i);
    for (int i = 0; i < LANES; i++)    if (mask_q[i]) last  = IW'(i);

    adj = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (IW'(i) >= first && IW'(i) <= last) begin
        if (!mask_q[i] || addr_q[i] != addr_q[first] + ADDR_W'(IW'(i) - first)) adj = 1'b0;
      end
    end

    // A read lane repeating an earlier active lane's address rides on that lane's fetch
    for (int i = 0; i < LANES; i++) begin
      issue[i] = mask_q[i];
      if (!write_q) begin
        for (int j = 0; j < i; j++) begin
          if (mask_q[j] && addr_q[j] == addr_q[i]) issue[i] = 1'b0;
        end
      end
    end

    cur = '0;
    for (int i = LANES-1; i >= 0; i--) if (pend_q[i]) cur = IW'(i);
  end

  logic [IW-1:0]     beat_lane;
  logic [ADDR_W-1:0] beat_addr;
  logic              last_beat;

  always_comb begin
    beat_lane = lane_q + beat_q;
    beat_addr = addr_q[lane_q] + ADDR_W'(beat_q);
    last_beat = ({1'b0, beat_q} == len_q - LW'(1));
  end

  // NOTE: combinational logic uses blocking '=' so later statements see earlier results.
  always_comb begin
    // NOTE: every _d and every output gets a default first; no path leaves one unassigned, so no latch.
    state_d = state_q;
    write_d = write_q;
    mask_d  = mask_q;
    pend_d  = pend_q;
    len_d   = len_q;
    lane_d  = lane_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    bus.req_ready     = 1'b0;
    bus.mem_cmd_valid = 1'b0;
    bus.mem_cmd_write = 1'b0;
    bus.mem_cmd_addr  = '0;
    bus.mem_cmd_len   = '0;
    bus.mem_wvalid    = 1'b0;
    bus.mem_wdata     = '0;
    bus.resp_valid    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          write_d = bus.req_write;
          mask_d  = bus.req_mask;
          for (int i = 0; i < LANES; i++) begin
            addr_d[i]  = bus.req_addr[i*ADDR_W +: ADDR_W];
            wdata_d[i] = bus.req_wdata[i*DATA_W +: DATA_W];
            rdata_d[i] = '0;
          end
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (mask_q == '0) begin
          state_d = S_RESP;
        end else if (adj) begin
          pend_d        = '0;
          pend_d[first] = 1'b1;
          len_d         = LW'(last - first) + LW'(1);
          state_d       = S_CMD;
        end else begin
          pend_d  = issue;
          len_d   = LW'(1);
          state_d = S_CMD;
        end
      end

      S_CMD: begin
        bus.mem_cmd_valid = 1'b1;
        bus.mem_cmd_write = write_q;
        bus.mem_cmd_addr  = addr_q[cur];
        bus.mem_cmd_len   = len_q;
        if (bus.mem_cmd_ready) begin
          pend_d[cur] = 1'b0;
          lane_d      = cur;
          beat_d      = '0;
          state_d     = write_q ? S_WDATA : S_RDATA;
        end
      end

      S_WDATA: begin
        bus.mem_wvalid = 1'b1;
        bus.mem_wdata  = wdata_q[beat_lane];
        if (bus.mem_wready) begin
          if (last_beat) state_d = (pend_q != '0) ? S_CMD : S_RESP;
          else           beat_d  = beat_q + IW'(1);
        end
      end

      S_RDATA: begin
        if (bus.mem_rvalid) begin
          for (int j = 0; j < LANES; j++) begin
            if (mask_q[j] && addr_q[j] == beat_addr) rdata_d[j] = bus.mem_rdata;
          end
          if (last_beat) state_d = (pend_q != '0) ? S_CMD : S_RESP;
          else           beat_d  = beat_q + IW'(1);
        end
      end

      S_RESP: begin
        bus.resp_valid = 1'b1;
        state_d        = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) bus.resp_rdata[i*DATA_W +: DATA_W] = rdata_q[i];
  end

  // NOTE: state registers use non-blocking '<=' so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      mask_q  <= '0;
      pend_q  <= '0;
      len_q   <= '0;
      lane_q  <= '0;
      beat_q  <= '0;
      // NOTE: the per-lane arrays are flops, not RAM; they are reset so resp_rdata reads 0 after reset.
      for (int i = 0; i < LANES; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        rdata_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      len_q   <= len_d;
      lane_q  <= lane_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_lane_mem_coalescer.sv
// Directed bench for lane_mem_coalescer: a one-cycle-latency memory responder plus monitor,
// and hand-computed expectations per request. Read beat data is {16'hDA7A, addr[15:0]}.
module tb_lane_mem_coalescer;
  localparam int LANES  = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lane_mem_coalescer_if #(.LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  lane_mem_coalescer #(.LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor + memory responder state (owned by the negedge process)
  int          cyc = 0;
  int          epoch = 0;
  int          seen_epoch = 0;
  int          acc_cyc;
  int          resp_cnt;
  int          resp_cyc;
  int          cmd_seen;
  logic [255:0] resp_data;
  logic [31:0] cmd_addr_q [$];
  int          cmd_len_q  [$];
  int          cmd_wr_q   [$];
  int          cmd_cyc_q  [$];
  logic [31:0] wd_q       [$];
  int          rd_left = 0;
  int          rd_wait = 0;
  logic [31:0] rd_addr = '0;

  logic [255:0] exp_rd;
  int hole_lanes [6] = '{0, 2, 4, 5, 6, 7};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (epoch != seen_epoch) begin
      cmd_addr_q.delete(); cmd_len_q.delete(); cmd_wr_q.delete(); cmd_cyc_q.delete(); wd_q.delete();
      acc_cyc = -1; resp_cnt = 0; resp_cyc = -1; cmd_seen = 0; resp_data = '0;
      seen_epoch = epoch;
    end
    if (reset) begin
      rd_left = 0; rd_wait = 0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
    end else begin
      bus.mem_rvalid = 1'b0;
      if (rd_left > 0) begin
        if (rd_wait > 0) rd_wait--;
        else begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = {16'hDA7A, rd_addr[15:0]};
          rd_addr++;
          rd_left--;
        end
      end
      if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
      if (bus.mem_cmd_valid) cmd_seen++;
      if (bus.mem_cmd_valid && bus.mem_cmd_ready) begin
        cmd_addr_q.push_back(bus.mem_cmd_addr);
        cmd_len_q.push_back(int'(bus.mem_cmd_len));
        cmd_wr_q.push_back(int'(bus.mem_cmd_write));
        cmd_cyc_q.push_back(cyc);
        if (!bus.mem_cmd_write) begin
          rd_wait = 1; rd_left = int'(bus.mem_cmd_len); rd_addr = bus.mem_cmd_addr;
        end
      end
      if (bus.mem_wvalid && bus.mem_wready) wd_q.push_back(bus.mem_wdata);
      if (bus.resp_valid) begin
        resp_cnt++; resp_cyc = cyc; resp_data = bus.resp_rdata;
      end
    end
  end

  function automatic logic [255:0] seq(input logic [31:0] base, input int step);
    logic [255:0] r;
    for (int i = 0; i < LANES; i++) r[i*32 +: 32] = base + 32'(i * step);
    return r;
  endfunction

  task automatic run_req(input string tag, input logic wr, input logic [7:0] mask,
                         input logic [255:0] addrs, input logic [255:0] wd);
    @(posedge clk); #1;
    epoch++;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_mask = mask;
    bus.req_addr  = addrs; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 200 && resp_cnt == 0; i++) begin @(posedge clk); #1; end
    repeat (3) begin @(posedge clk); #1; end
    check({tag, "_accepted"}, acc_cyc >= 0, 1'b1);
    check({tag, "_resp_count"}, resp_cnt, 1);
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_mask = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_cmd_ready = 1'b1; bus.mem_wready = 1'b1;
    repeat (2) @(posedge clk); #1;

    check("rst_req_ready",  bus.req_ready,     1'b1);
    check("rst_cmd_valid",  bus.mem_cmd_valid, 1'b0);
    check("rst_cmd_len",    bus.mem_cmd_len,   0);
    check("rst_wvalid",     bus.mem_wvalid,    1'b0);
    check("rst_resp_valid", bus.resp_valid,    1'b0);
    check("rst_resp_rdata", bus.resp_rdata,    '0);
    reset = 1'b0;

    // 1: full contiguous read
    run_req("adj_rd", 1'b0, 8'hFF, seq(32'h100, 1), '0);
    check("adj_rd_ncmd", cmd_addr_q.size(), 1);
    if (cmd_addr_q.size() > 0) begin
      check("adj_rd_addr", cmd_addr_q[0], 32'h100);
      check("adj_rd_len",  cmd_len_q[0], 8);
      check("adj_rd_cmd_cycle", cmd_cyc_q[0] - acc_cyc, 2);
    end
    check("adj_rd_resp_cycle", resp_cyc - acc_cyc, 12);
    exp_rd = seq(32'hDA7A0100, 1);
    check("adj_rd_data", resp_data, exp_rd);

    // 2: contiguous partial write, lanes 2..5
    run_req("adj_wr", 1'b1, 8'h3C, seq(32'h40, 1), seq(32'hC0DE0000, 1));
    check("adj_wr_ncmd", cmd_addr_q.size(), 1);
    if (cmd_addr_q.size() > 0) begin
      check("adj_wr_addr",  cmd_addr_q[0], 32'h42);
      check("adj_wr_len",   cmd_len_q[0], 4);
      check("adj_wr_write", cmd_wr_q[0], 1);
    end
    check("adj_wr_nbeats", wd_q.size(), 4);
    for (int i = 0; i < wd_q.size() && i < 4; i++)
      check($sformatf("adj_wr_beat%0d", i), wd_q[i], 32'hC0DE0002 + 32'(i));
    check("adj_wr_resp_cycle", resp_cyc - acc_cyc, 7);
    check("adj_wr_rdata_zero", resp_data, '0);

    // 3: mask with a hole -> single-word commands for lanes 0,2,4,5,6,7
    run_req("hole", 1'b0, 8'hF5, seq(32'h80, 1), '0);
    check("hole_ncmd", cmd_addr_q.size(), 6);
    for (int i = 0; i < cmd_addr_q.size() && i < 6; i++) begin
      check($sformatf("hole_addr%0d", i), cmd_addr_q[i], 32'h80 + 32'(hole_lanes[i]));
      check($sformatf("hole_len%0d", i),  cmd_len_q[i], 1);
    end
    exp_rd = '0;
    for (int i = 0; i < 6; i++) exp_rd[hole_lanes[i]*32 +: 32] = 32'hDA7A0080 + 32'(hole_lanes[i]);
    check("hole_data", resp_data, exp_rd);

    // 4: broadcast read, every lane on one address
    run_req("bcast", 1'b0, 8'hFF, seq(32'h200, 0), '0);
    check("bcast_ncmd", cmd_addr_q.size(), 1);
    if (cmd_addr_q.size() > 0) begin
      check("bcast_addr", cmd_addr_q[0], 32'h200);
      check("bcast_len",  cmd_len_q[0], 1);
    end
    exp_rd = seq(32'hDA7A0200, 0);
    check("bcast_data", resp_data, exp_rd);

    // 4b: duplicate-address writes are not merged
    run_req("dupwr", 1'b1, 8'h03, seq(32'h50, 0), seq(32'hAAAA0000, 1));
    check("dupwr_ncmd", cmd_addr_q.size(), 2);
    check("dupwr_nbeats", wd_q.size(), 2);
    for (int i = 0; i < wd_q.size() && i < 2; i++)
      check($sformatf("dupwr_beat%0d", i), wd_q[i], 32'hAAAA0000 + 32'(i));

    // 5: zero mask
    run_req("zero", 1'b0, 8'h00, seq(32'h10, 1), '0);
    check("zero_cmd_seen", cmd_seen, 0);
    check("zero_resp_cycle", resp_cyc - acc_cyc, 2);
    check("zero_data", resp_data, '0);

    // 6: command stall, then reset in the middle of the read data phase
    @(posedge clk); #1;
    epoch++;
    bus.mem_cmd_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_mask = 8'hFF;
    bus.req_addr = seq(32'h300, 1); bus.req_wdata = '0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d_valid", k), bus.mem_cmd_valid, 1'b1);
      check($sformatf("stall%0d_addr", k),  bus.mem_cmd_addr, 32'h300);
      check($sformatf("stall%0d_len", k),   bus.mem_cmd_len, 8);
    end
    @(posedge clk); #1;
    bus.mem_cmd_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("midrd_lane0_captured", bus.resp_rdata[31:0], 32'hDA7A0300);
    reset = 1'b1;
    #1;
    check("midrd_rst_req_ready", bus.req_ready, 1'b1);
    check("midrd_rst_rdata", bus.resp_rdata, '0);
    check("midrd_rst_cmd_valid", bus.mem_cmd_valid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (20) @(posedge clk); #1;
    check("midrd_no_resp", resp_cnt, 0);
    check("midrd_idle_ready", bus.req_ready, 1'b1);

    // recovery after reset, with an address run that wraps past the top of the address space
    run_req("wrap", 1'b0, 8'h0F, seq(32'hFFFFFFFF, 1), '0);
    check("wrap_ncmd", cmd_addr_q.size(), 1);
    if (cmd_addr_q.size() > 0) begin
      check("wrap_addr", cmd_addr_q[0], 32'hFFFFFFFF);
      check("wrap_len",  cmd_len_q[0], 4);
    end
    check("wrap_resp_cycle", resp_cyc - acc_cyc, 8);
    exp_rd = '0;
    exp_rd[31:0] = 32'hDA7AFFFF; exp_rd[63:32] = 32'hDA7A0000;
    exp_rd[95:64] = 32'hDA7A0001; exp_rd[127:96] = 32'hDA7A0002;
    check("wrap_data", resp_data, exp_rd);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
